// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage: PC, imem address, IF/ID register; optional FETCH_PERF_EN counters
module fetch_stage #(
    parameter int N   = 32,
    parameter int INS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    output logic [N-1:0] pc,
    input  logic [N-1:0] instruction,
    output logic [N-1:0] if_id_instr,
    output logic [N-1:0] if_id_pc,
    output logic         if_id_valid,
    output logic         done
`ifdef FETCH_PERF_EN
    ,
    output logic [N-1:0] perf_fetched,
    output logic [N-1:0] perf_stalls
`endif
);

    localparam logic [N-1:0] LAST_PC = N'(INS - 1);
    localparam logic [N-1:0] PC_LIMIT = N'(INS);

    typedef enum logic {
        S_RUN,
        S_DONE
    } state_t;

    state_t state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RUN;
            pc          <= '0;
            if_id_instr <= '0;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
            done        <= 1'b0;
        end else if (branch_taken) begin
            // The word currently on imem is dropped: one bubble per redirect.
            if_id_instr <= '0;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
            if (branch_target < PC_LIMIT) begin
                pc    <= branch_target;
                state <= S_RUN;
                done  <= 1'b0;
            end else begin
                state <= S_DONE;
                done  <= 1'b1;
            end
        end else if (!stall) begin
            if (state == S_RUN) begin
                if_id_instr <= instruction;
                if_id_pc    <= pc;
                if_id_valid <= 1'b1;
                if (pc == LAST_PC) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end else begin
                    pc <= pc + 1'b1;
                end
            end else begin
                // Last instruction is presented exactly once, then bubbles.
                if_id_instr <= '0;
                if_id_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic fetch_event;
    logic stall_event;

    assign fetch_event = !branch_taken && !stall && (state == S_RUN);
    assign stall_event = !branch_taken && stall && (state == S_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stalls  <= '0;
        end else begin
            if (fetch_event && (perf_fetched != '1))
                perf_fetched <= perf_fetched + 1'b1;
            if (stall_event && (perf_stalls != '1))
                perf_stalls <= perf_stalls + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

    localparam int N   = 32;
    localparam int INS = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall;
    logic         branch_taken;
    logic [N-1:0] branch_target;
    logic [N-1:0] pc;
    logic [N-1:0] instruction;
    logic [N-1:0] if_id_instr;
    logic [N-1:0] if_id_pc;
    logic         if_id_valid;
    logic         done;
`ifdef FETCH_PERF_EN
    logic [N-1:0] perf_fetched;
    logic [N-1:0] perf_stalls;
`endif

    logic [N-1:0] imem [0:INS-1];

    always #5 clk = ~clk;

    assign instruction = (pc < N'(INS)) ? imem[pc[3:0]] : 32'hDEAD_BEEF;

    fetch_stage #(.N(N), .INS(INS)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .instruction   (instruction),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_valid   (if_id_valid),
        .done          (done)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_stalls   (perf_stalls)
`endif
    );

    typedef struct {
        logic         rst;
        logic         stall;
        logic         br;
        logic [N-1:0] tgt;
        logic [N-1:0] e_pc;
        logic [N-1:0] e_ipc;
        logic [N-1:0] e_instr;
        logic         e_v;
        logic         e_d;
    } vec_t;

    typedef struct {
        logic [N-1:0] pc;
        logic [N-1:0] instr;
    } fetch_t;

    vec_t   vecs[$];
    vec_t   exp_q[$];
    fetch_t fetch_q[$];
    int     checks = 0;
    int     errors = 0;

    function automatic vec_t mk(input logic r, input logic s, input logic b, input int t,
                                input int epc, input int eipc, input int ein,
                                input logic ev, input logic ed);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.tgt = N'(t);
        v.e_pc = N'(epc); v.e_ipc = N'(eipc); v.e_instr = N'(ein);
        v.e_v = ev; v.e_d = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic b, input logic [N-1:0] t);
        rst = r; stall = s; branch_taken = b; branch_target = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < INS; i++) imem[i] = 32'hA0 + N'(i);
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;

        // rst stl br tgt   pc ifpc instr   v d
        vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0,      0, 0));
        vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0,      0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  1, 0, 'hA0,   1, 0));
        vecs.push_back(mk(0, 0, 0, 0,  2, 1, 'hA1,   1, 0));
        vecs.push_back(mk(0, 0, 0, 0,  3, 2, 'hA2,   1, 0));
        vecs.push_back(mk(0, 0, 0, 0,  4, 3, 'hA3,   1, 0));
        vecs.push_back(mk(0, 1, 0, 0,  4, 3, 'hA3,   1, 0));
        vecs.push_back(mk(0, 1, 0, 0,  4, 3, 'hA3,   1, 0));
        vecs.push_back(mk(0, 1, 0, 0,  4, 3, 'hA3,   1, 0));
        vecs.push_back(mk(0, 0, 0, 0,  5, 4, 'hA4,   1, 0));
        vecs.push_back(mk(0, 1, 1, 1,  1, 0, 0,      0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  2, 1, 'hA1,   1, 0));
        for (int i = 2; i < 9; i++)
            vecs.push_back(mk(0, 0, 0, 0, i + 1, i, 'hA0 + i, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,  9, 9, 'hA9,   1, 1));
        vecs.push_back(mk(0, 0, 0, 0,  9, 9, 0,      0, 1));
        vecs.push_back(mk(0, 1, 0, 0,  9, 9, 0,      0, 1));
        vecs.push_back(mk(0, 0, 1, 12, 9, 0, 0,      0, 1));
        vecs.push_back(mk(0, 0, 1, 0,  0, 0, 0,      0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  1, 0, 'hA0,   1, 0));
        vecs.push_back(mk(0, 0, 1, 10, 1, 0, 0,      0, 1));
        vecs.push_back(mk(0, 0, 1, 9,  9, 0, 0,      0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  9, 9, 'hA9,   1, 1));
        vecs.push_back(mk(0, 0, 0, 0,  9, 9, 0,      0, 1));
        vecs.push_back(mk(0, 0, 1, 3,  3, 0, 0,      0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  4, 3, 'hA3,   1, 0));
        vecs.push_back(mk(1, 1, 1, 7,  0, 0, 0,      0, 0));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t e;
            exp_q.push_back(vecs[i]);
            drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt);
            e = exp_q.pop_front();
            chk($sformatf("v%0d pc", i), pc, e.e_pc);
            chk($sformatf("v%0d if_id_pc", i), if_id_pc, e.e_ipc);
            chk($sformatf("v%0d if_id_instr", i), if_id_instr, e.e_instr);
            chk($sformatf("v%0d if_id_valid", i), N'(if_id_valid), N'(e.e_v));
            chk($sformatf("v%0d done", i), N'(done), N'(e.e_d));
        end

        // Free run from reset to done with a cycle budget; every issued word is scoreboarded.
        begin
            int model_pc = 0;
            int issued   = 0;
            int cycles   = 0;
            drive(1'b1, 1'b0, 1'b0, '0);
            while (!done && cycles < 20) begin
                fetch_t f;
                if (model_pc < INS) begin
                    f.pc = N'(model_pc); f.instr = 32'hA0 + N'(model_pc);
                    fetch_q.push_back(f);
                    model_pc++;
                end
                drive(1'b0, 1'b0, 1'b0, '0);
                cycles++;
                if (if_id_valid) begin
                    if (fetch_q.size() == 0) begin
                        chk("run extra valid", N'(1), N'(0));
                    end else begin
                        f = fetch_q.pop_front();
                        chk("run if_id_pc", if_id_pc, f.pc);
                        chk("run if_id_instr", if_id_instr, f.instr);
                        issued++;
                    end
                end
            end
            chk("run done reached", N'(done), N'(1));
            chk("run issued count", N'(issued), N'(INS));
            chk("run cycles", N'(cycles), N'(INS));
            chk("run final pc", pc, N'(INS - 1));
        end

`ifdef FETCH_PERF_EN
        drive(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b0, '0);
        chk("perf pc", pc, N'(5));
        chk("perf_fetched", perf_fetched, N'(5));
        chk("perf_stalls", perf_stalls, N'(3));
        drive(1'b0, 1'b1, 1'b1, N'(2));
        chk("perf_stalls branch", perf_stalls, N'(3));
        drive(1'b1, 1'b0, 1'b0, '0);
        chk("perf_fetched rst", perf_fetched, N'(0));
        chk("perf_stalls rst", perf_stalls, N'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
